// File: rtl/mips_cpu_mult_div.sv
// HI/LO multiply-divide unit: radix-2 iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO/MFHI/MFLO.
// Latency WIDTH+1 cycles from start to HI/LO update; a start while busy is dropped, so the datapath stalls on busy.
module mips_cpu_mult_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] read_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_DIVU  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_MULT  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MFHI  = 3'b110;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] prod;      // multiply accumulator; low half doubles as the quotient shifter
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   a_raw;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;

   logic               is_signed;
   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     shifted;
   logic               ge;
   logic [WIDTH-1:0]   sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;

   assign is_signed = (op == OP_MULT) || (op == OP_DIV);
   assign sa        = is_signed & a[WIDTH-1];
   assign sb        = is_signed & b[WIDTH-1];
   // Negating the most negative value yields the same bit pattern, which read unsigned is the correct magnitude.
   assign abs_a     = sa ? -a : a;
   assign abs_b     = sb ? -b : b;

   assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
   // The partial remainder is always below the divisor, so WIDTH bits hold it and the shifted trial value needs WIDTH+1.
   assign shifted   = {rem, prod[WIDTH-1]};
   assign ge        = shifted >= {1'b0, divisor};
   assign sub       = shifted[WIDTH-1:0] - divisor;

   assign prod_fix  = neg_q ? -prod : prod;
   assign q_fix     = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
   assign r_fix     = neg_r ? -rem : rem;

   assign busy      = (state != S_IDLE);
   assign read_data = (op == OP_MFHI) ? hi : lo;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         count   <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         prod    <= '0;
         mcand   <= '0;
         divisor <= '0;
         rem     <= '0;
         a_raw   <= '0;
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        is_div  <= !op[0];
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        a_raw   <= a;
                        mcand   <= abs_a;
                        divisor <= abs_b;
                        rem     <= '0;
                        prod    <= {{WIDTH{1'b0}}, (op[0] ? abs_b : abs_a)};
                        count   <= '0;
                        state   <= S_CALC;
                     end
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
               if (is_div) begin
                  rem              <= ge ? sub : shifted[WIDTH-1:0];
                  prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], ge};
               end else begin
                  prod <= {mul_sum, prod[WIDTH-1:1]};
               end
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1))
                  state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  if (divisor == '0) begin
                     hi <= a_raw;
                     lo <= {WIDTH{1'b1}};
                  end else begin
                     hi <= r_fix;
                     lo <= q_fix;
                  end
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// Self-checking bench for mips_cpu_mult_div: scoreboard of expected HI/LO per mult/div, compared on done.
module tb_mips_cpu_mult_div;

   localparam logic [2:0] DIVU = 3'b000, MULTU = 3'b001, DIV = 3'b010, MULT = 3'b011;
   localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, MFHI = 3'b110, MFLO = 3'b111;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] read_data, hi, lo;

   int tests = 0;
   int fails = 0;
   logic [63:0] sb_q[$];

   mips_cpu_mult_div #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .read_data(read_data), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      logic [63:0] p, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         MULTU: p = {32'b0, x} * {32'b0, y};
         MULT:  p = sx * sy;
         DIVU: begin
            if (y == 0) p = {x, 32'hFFFF_FFFF};
            else p = {x % y, x / y};
         end
         default: begin
            if (y == 0) p = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      return p;
   endfunction

   // Caller is at a negedge; start is sampled at the next posedge, then op/a/b are scrambled.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
      start = 1'b1; op = o; a = x; b = y;
      if (push) sb_q.push_back(model(o, x, y));
      @(posedge clk); #1;
      start = 1'b0; op = MFLO; a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(input int exp_cycles, input string name);
      int cnt;
      bit early_done;
      logic [63:0] e;
      cnt = 0;
      early_done = 0;
      @(negedge clk);
      while (busy === 1'b1 && cnt < 200) begin
         if (done === 1'b1) early_done = 1;
         cnt++;
         @(negedge clk);
      end
      tests++;
      if (cnt != exp_cycles) begin fails++; $display("FAIL %s busy_cycles got %0d want %0d", name, cnt, exp_cycles); end
      tests++;
      if (early_done) begin fails++; $display("FAIL %s done_while_busy got 1 want 0", name); end
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL %s done_pulse got %b want 1", name, done); end
      if (sb_q.size() == 0) begin
         tests++; fails++; $display("FAIL %s scoreboard empty got 0 entries want 1", name);
      end else begin
         e = sb_q.pop_front();
         tests++;
         if (hi !== e[63:32]) begin fails++; $display("FAIL %s hi got %h want %h", name, hi, e[63:32]); end
         tests++;
         if (lo !== e[31:0]) begin fails++; $display("FAIL %s lo got %h want %h", name, lo, e[31:0]); end
      end
   endtask

   task automatic check_done_low(input string name);
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL %s done_after_pulse got %b want 0", name, done); end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done got %b want 0", done); end
      tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset hi got %h want 0", hi); end
      tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset lo got %h want 0", lo); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult;
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done(33, "multu_max");
      tests++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         fails++; $display("FAIL multu_max_const got %h_%h want fffffffe_00000001", hi, lo); end
      check_done_low("multu_max");
      issue(MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1); wait_done(33, "mult_neg3x7");
      tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         fails++; $display("FAIL mult_neg3x7_const got %h_%h want ffffffff_ffffffeb", hi, lo); end
      check_done_low("mult_neg3x7");
      issue(MULT, 32'h8000_0000, 32'h8000_0000, 1); wait_done(33, "mult_minxmin");
      check_done_low("mult_minxmin");
   endtask

   task automatic test_div;
      issue(DIV, 32'hFFFF_FFF9, 32'h2, 1);          wait_done(33, "div_neg7by2");
      tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         fails++; $display("FAIL div_neg7by2_const got %h_%h want ffffffff_fffffffd", hi, lo); end
      check_done_low("div_neg7by2");
      issue(DIVU, 32'h7, 32'h2, 1);                 wait_done(33, "divu_7by2");
      check_done_low("divu_7by2");
      issue(DIVU, 32'hFFFF_FFFF, 32'h10, 1);        wait_done(33, "divu_maxby16");
      check_done_low("divu_maxby16");
   endtask

   task automatic test_div_boundary;
      issue(DIVU, 32'h0000_1234, 32'h0, 1);         wait_done(33, "divu_by0");
      tests++; if (hi !== 32'h0000_1234 || lo !== 32'hFFFF_FFFF) begin
         fails++; $display("FAIL divu_by0_const got %h_%h want 00001234_ffffffff", hi, lo); end
      check_done_low("divu_by0");
      issue(DIV, 32'hFFFF_FF00, 32'h0, 1);          wait_done(33, "div_by0");
      check_done_low("div_by0");
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);  wait_done(33, "div_overflow");
      tests++; if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         fails++; $display("FAIL div_overflow_const got %h_%h want 00000000_80000000", hi, lo); end
      check_done_low("div_overflow");
   endtask

   task automatic test_move;
      logic [31:0] old_hi;
      start = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      op = MTLO; a = 32'h0BAD_F00D;
      @(posedge clk); #1;
      start = 1'b0; op = MFHI;
      @(negedge clk);
      tests++; if (read_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mfhi got %h want deadbeef", read_data); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL move_flags busy/done got %b%b want 00", busy, done); end
      op = MFLO; #1;
      tests++; if (read_data !== 32'h0BAD_F00D) begin fails++; $display("FAIL mflo got %h want 0badf00d", read_data); end
      old_hi = 32'hDEAD_BEEF;
      @(negedge clk);
      // MFHI while busy returns old HI; MTHI while busy is dropped.
      issue(MULT, 32'h0000_1111, 32'hFFFF_FFFE, 1);
      repeat (5) @(negedge clk);
      op = MFHI; #1;
      tests++; if (read_data !== old_hi) begin fails++; $display("FAIL mfhi_busy got %h want %h", read_data, old_hi); end
      start = 1'b1; op = MTHI; a = 32'h1234_5678;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(28, "mthi_mid_mult");
      check_done_low("mthi_mid_mult");
   endtask

   task automatic test_back_to_back;
      issue(MULTU, 32'h0001_0000, 32'h0001_0000, 1); wait_done(33, "b2b_first");
      issue(DIV, 32'hFFFF_FF85, 32'h0000_000A, 1);   wait_done(33, "b2b_second");
      issue(DIVU, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);  wait_done(33, "b2b_third");
      check_done_low("b2b_third");
   endtask

   task automatic test_random;
      logic [2:0] o;
      logic [31:0] x, y;
      for (int i = 0; i < 8; i++) begin
         o = 3'($urandom_range(0, 3));
         x = $urandom;
         y = (i == 3) ? 32'h0 : ((i[0]) ? $urandom : 32'($urandom_range(1, 300)));
         issue(o, x, y, 1);
         wait_done(33, "random");
      end
      check_done_low("random");
   endtask

   task automatic test_reset_mid_calc;
      bit saw_done;
      issue(MULTU, 32'hFFFF_FFFF, 32'h0000_0003, 0);
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid busy got %b want 0", busy); end
      tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL rst_mid hilo got %h_%h want 0_0", hi, lo); end
      saw_done = 0;
      repeat (40) begin
         if (done === 1'b1) saw_done = 1;
         @(negedge clk);
      end
      tests++; if (saw_done) begin fails++; $display("FAIL rst_mid done got 1 want 0"); end
      issue(MULTU, 32'h3, 32'h5, 1); wait_done(33, "post_reset_multu");
      tests++; if (hi !== 32'h0 || lo !== 32'hF) begin fails++; $display("FAIL post_reset_const got %h_%h want 0_f", hi, lo); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_mult();
      test_div();
      test_div_boundary();
      test_move();
      test_back_to_back();
      test_random();
      test_reset_mid_calc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
